// File: rtl/dm_store_buffer_if.sv
// Store/load/memory bus bundle for dm_store_buffer.
// Handshake: a store transfers on a rising edge where st_req && st_ready are both high;
// ld_stall high means the load in ld_addr must be held until a cycle where it is low.
interface dm_store_buffer_if #(
  parameter int AW = 10
);
  logic          st_req;
  logic [11:0]   st_addr;
  logic [1:0]    st_size;
  logic [31:0]   st_data;
  logic          st_ready;
  logic          align_err;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_stall;
  logic [AW-1:0] dm_A;
  logic          dm_WE;
  logic [3:0]    dm_BE;
  logic [31:0]   dm_WD;

  modport master (
    output st_req, st_addr, st_size, st_data, ld_req, ld_addr,
    input  st_ready, align_err, ld_stall, dm_A, dm_WE, dm_BE, dm_WD
  );

  modport slave (
    input  st_req, st_addr, st_size, st_data, ld_req, ld_addr,
    output st_ready, align_err, ld_stall, dm_A, dm_WE, dm_BE, dm_WD
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-store FIFO in front of the data memory write port; loads own the bus unless they hit.
// Optional store merging into the tail entry is enabled by defining STBUF_MERGE_EN.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  dm_store_buffer_if.slave       bus,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]  addr_q [DEPTH];
  logic [3:0]     be_q   [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]  head_q, tail_q, last_idx;
  logic [PW:0]    count_q;
  logic           align_err_q;

  logic           aligned, full, hit, load_owns, deq, merge, accept, alloc;
  logic [3:0]     be_st;
  logic [31:0]    lane_st, lane_mask;
  logic [AW-1:0]  st_word;
  logic [3:0]     head_be;
  logic [31:0]    head_data;

  assign st_word  = AW'(bus.st_addr[11:2]);
  assign last_idx = tail_q - PW'(1);
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign count    = count_q;
  assign bus.align_err = align_err_q;
  assign head_be   = be_q[head_q];
  assign head_data = data_q[head_q];
  assign lane_mask = {{8{be_st[3]}}, {8{be_st[2]}}, {8{be_st[1]}}, {8{be_st[0]}}};

  // Alignment check and lane placement of the incoming store
  always_comb begin
    aligned = 1'b1;
    be_st   = 4'b0000;
    lane_st = 32'h0;
    case (bus.st_size)
      2'b00: begin
        be_st   = 4'b0001 << bus.st_addr[1:0];
        lane_st = 32'(bus.st_data[7:0]) << {bus.st_addr[1:0], 3'b000};
      end
      2'b01: begin
        aligned = !bus.st_addr[0];
        be_st   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        lane_st = bus.st_addr[1] ? {bus.st_data[15:0], 16'h0} : {16'h0, bus.st_data[15:0]};
      end
      2'b10: begin
        aligned = (bus.st_addr[1:0] == 2'b00);
        be_st   = 4'b1111;
        lane_st = bus.st_data;
      end
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == bus.ld_addr) hit = 1'b1;
    end
    hit = hit && bus.ld_req;
  end

  // A hitting load never takes the bus, so the drain always proceeds under a stall
  assign load_owns    = bus.ld_req && !hit;
  assign deq          = !rst && !load_owns && !empty;
  assign bus.ld_stall = !rst && hit;
  assign bus.dm_WE    = deq;
  assign bus.dm_A     = load_owns ? bus.ld_addr : (deq ? addr_q[head_q] : '0);

  always_comb begin
    bus.dm_BE = 4'b0000;
    bus.dm_WD = 32'h0;
    if (deq) begin
      bus.dm_BE = head_be;
      case (head_be)
        4'b0001: bus.dm_WD = {24'h0, head_data[7:0]};
        4'b0010: bus.dm_WD = {24'h0, head_data[15:8]};
        4'b0100: bus.dm_WD = {24'h0, head_data[23:16]};
        4'b1000: bus.dm_WD = {24'h0, head_data[31:24]};
        4'b1100: bus.dm_WD = {16'h0, head_data[31:16]};
        default: bus.dm_WD = head_data;
      endcase
    end
  end

`ifdef STBUF_MERGE_EN
  logic [3:0] be_merge;
  assign be_merge = be_q[last_idx] | be_st;
  // The tail entry is only mergeable if it is not the one leaving this cycle
  assign merge = bus.st_req && aligned && !empty && (addr_q[last_idx] == st_word) &&
                 !(deq && count_q == (PW+1)'(1)) &&
                 (be_merge == 4'b0011 || be_merge == 4'b1100 || be_merge == 4'b1111);
`else
  assign merge = 1'b0;
`endif

  assign bus.st_ready = !full || merge;
  assign accept       = bus.st_req && bus.st_ready && aligned;
  assign alloc        = accept && !merge;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= bus.st_req && !aligned;
      if (alloc) begin
        addr_q[tail_q]  <= st_word;
        be_q[tail_q]    <= be_st;
        data_q[tail_q]  <= lane_st;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
`ifdef STBUF_MERGE_EN
      if (merge) begin
        be_q[last_idx]   <= be_merge;
        data_q[last_idx] <= (data_q[last_idx] & ~lane_mask) | (lane_st & lane_mask);
      end
`endif
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      case ({alloc, deq})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: expected memory writes are queued at store
// acceptance and compared whenever the buffer drives dm_WE.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty;
  logic [2:0] count;

  dm_store_buffer_if #(.AW(AW)) bus ();

  dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .empty (empty),
    .count (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [45:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected memory-format write {word addr, BE, WD} for a legal store
  function automatic logic [45:0] exp_for(input logic [11:0] a, input logic [1:0] sz,
                                          input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] wd;
    case (sz)
      2'b00:   begin be = 4'b0001 << a[1:0];              wd = {24'h0, d[7:0]};  end
      2'b01:   begin be = a[1] ? 4'b1100 : 4'b0011;       wd = {16'h0, d[15:0]}; end
      default: begin be = 4'b1111;                        wd = d;                end
    endcase
    return {a[11:2], be, wd};
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    logic [45:0] e;
    if (!rst && bus.dm_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.dm_WE), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.dm_A), 64'(e[45:36]));
        check("wr_be", 64'(bus.dm_BE), 64'(e[35:32]));
        check("wr_data", 64'(bus.dm_WD), 64'(e[31:0]));
      end
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic store(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d,
                       input bit push);
    bit done = 1'b0;
    bus.st_req  = 1'b1;
    bus.st_addr = a;
    bus.st_size = sz;
    bus.st_data = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.st_ready) begin
        done = 1'b1;
        if (push) exp_q.push_back(exp_for(a, sz, d));
      end
      @(posedge clk); #1;
    end
    bus.st_req = 1'b0;
    if (!done) check("store_timeout", 64'(bus.st_ready), 64'd1);
  endtask

  task automatic bad_store(input logic [11:0] a, input logic [1:0] sz, input string tag);
    bus.st_req  = 1'b1;
    bus.st_addr = a;
    bus.st_size = sz;
    bus.st_data = $urandom;
    @(posedge clk); #1;
    bus.st_req = 1'b0;
    @(negedge clk);
    check({tag, "_err_pulse"}, 64'(bus.align_err), 64'd1);
    check({tag, "_count"}, 64'(count), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_err_clear"}, 64'(bus.align_err), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    while (!empty && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_drained"}, 64'(empty), 64'd1);
  endtask

  initial begin
    logic [31:0] d5;
    bus.st_req  = 1'b0;
    bus.st_addr = '0;
    bus.st_size = '0;
    bus.st_data = '0;
    bus.ld_req  = 1'b0;
    bus.ld_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_st_ready", 64'(bus.st_ready), 64'd1);
    check("rst_we", 64'(bus.dm_WE), 64'd0);
    check("rst_align_err", 64'(bus.align_err), 64'd0);
    check("rst_ld_stall", 64'(bus.ld_stall), 64'd0);
    @(posedge clk); #1;

    // word store, first-write latency
    store(12'h010, 2'b10, 32'h12345678, 1'b1);
    @(negedge clk);
    check("sw_latency_we", 64'(bus.dm_WE), 64'd1);
    @(posedge clk); #1;
    check("sw_then_empty", 64'(empty), 64'd1);

    // byte and upper-half stores, with junk above the used bits
    store(12'h013, 2'b00, 32'hFFFFFFAB, 1'b1);
    store(12'h022, 2'b01, 32'h1234BEEF, 1'b1);
    wait_empty("sb_sh");

    // rejected stores
    bad_store(12'h001, 2'b01, "sh_mis");
    bad_store(12'h002, 2'b10, "sw_mis");
    bad_store(12'h000, 2'b11, "size_ill");

    // fill while a non-matching load owns the bus
    bus.ld_req  = 1'b1;
    bus.ld_addr = 10'h3FF;
    for (int i = 0; i < DEPTH; i++) store(12'(12'h100 + i * 4), 2'b10, $urandom, 1'b1);
    @(negedge clk);
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_st_ready", 64'(bus.st_ready), 64'd0);
    check("fill_we", 64'(bus.dm_WE), 64'd0);
    check("fill_dm_a", 64'(bus.dm_A), 64'h3FF);
    check("fill_ld_stall", 64'(bus.ld_stall), 64'd0);
    @(posedge clk); #1;
    d5 = $urandom;
    bus.st_req  = 1'b1;
    bus.st_addr = 12'h200;
    bus.st_size = 2'b10;
    bus.st_data = d5;
    repeat (3) begin @(posedge clk); #1; end
    check("fill_held_count", 64'(count), 64'(DEPTH));
    bus.ld_req = 1'b0;
    store(12'h200, 2'b10, d5, 1'b1);
    wait_empty("fill");

    // load hitting the younger of two pending stores
    bus.ld_req  = 1'b1;
    bus.ld_addr = 10'h3FF;
    store(12'h040, 2'b10, $urandom, 1'b1);
    store(12'h044, 2'b10, $urandom, 1'b1);
    bus.ld_addr = 10'h011;
    @(negedge clk);
    check("hit_stall_c1", 64'(bus.ld_stall), 64'd1);
    check("hit_we_c1", 64'(bus.dm_WE), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("hit_stall_c2", 64'(bus.ld_stall), 64'd1);
    check("hit_we_c2", 64'(bus.dm_WE), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("hit_stall_c3", 64'(bus.ld_stall), 64'd0);
    check("hit_dm_a_c3", 64'(bus.dm_A), 64'h011);
    check("hit_we_c3", 64'(bus.dm_WE), 64'd0);
    @(posedge clk); #1;
    bus.ld_req = 1'b0;

    // two adjacent bytes into one word while draining is blocked
    bus.ld_req  = 1'b1;
    bus.ld_addr = 10'h3FF;
    store(12'h020, 2'b00, 32'h00000011, 1'b0);
    store(12'h021, 2'b00, 32'h00000022, 1'b0);
    @(negedge clk);
`ifdef STBUF_MERGE_EN
    check("merge_count", 64'(count), 64'd1);
    exp_q.push_back({10'h008, 4'b0011, 32'h00002211});
`else
    check("merge_count", 64'(count), 64'd2);
    exp_q.push_back({10'h008, 4'b0001, 32'h00000011});
    exp_q.push_back({10'h008, 4'b0010, 32'h00000022});
`endif
    @(posedge clk); #1;
    bus.ld_req = 1'b0;
    wait_empty("merge");

    // reset while draining discards the rest
    bus.ld_req = 1'b1;
    store(12'h300, 2'b10, $urandom, 1'b1);
    store(12'h304, 2'b10, $urandom, 1'b1);
    bus.ld_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_we", 64'(bus.dm_WE), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_count", 64'(count), 64'd0);
    check("rst_mid_empty", 64'(empty), 64'd1);
    @(negedge clk);
    check("rst_mid_we_after", 64'(bus.dm_WE), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-store FIFO between the MEM-stage store path and the 4 KB data memory.
- Accepts sb/sh/sw stores and checks their alignment.
- Holds each store as lane-positioned data plus a byte mask, and drains one entry per cycle into the memory's single write port.
- Loads own the memory address bus. A load that hits a pending store is stalled until that store has drained, so read-after-write order is preserved.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, 2..16)
- AW, 10, word-address width (matches memory A[11:2])

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- st_req  in  1  store request from MEM stage
- st_addr  in  12  byte address of store
- st_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- st_data  in  32  store data, right-justified
- st_ready  out  1  buffer can accept a store this cycle
- align_err  out  1  one-cycle pulse: rejected misaligned/illegal store
- ld_req  in  1  load request from MEM stage
- ld_addr  in  AW  load word address
- ld_stall  out  1  load must be held; pipeline freezes
- dm_A  out  AW  memory word address
- dm_WE  out  1  memory write enable
- dm_BE  out  4  memory byte enable
- dm_WD  out  32  memory write data (memory format)
- empty  out  1  no valid entries
- count  out  log2(DEPTH)+1  number of valid entries

Behaviour:
- Reset
  - Clears the valid bits, head/tail pointers and count.
  - Resulting output values: empty=1, count=0, st_ready=1, dm_WE=0, align_err=0, ld_stall=0.
  - Reset asserted mid-drain discards all pending stores. No write is issued on the reset edge.
- Alignment (combinational on st_*)
  - sh with st_addr[0]=1 is misaligned.
  - sw with st_addr[1:0]!=0 is misaligned.
  - st_size=11 is illegal.
  - Misaligned or illegal store: not enqueued; align_err=1 on the next cycle for exactly one cycle.
- Entry format
  - {word addr, BE[3:0], lane data[31:0]}.
  - sb: BE=0001<<addr[1:0], byte placed in lane addr[1:0].
  - sh: BE=0011 or 1100 per addr[1], half placed in its lane.
  - sw: BE=1111.
- Enqueue
  - st_ready = !full. Full is judged from the current count only; a dequeue in the same cycle does not free a slot for the incoming store.
  - A store is accepted when st_req && st_ready && aligned.
  - It is written at the tail on posedge; count increments.
- Bus arbitration (combinational)
  - Load hit: ld_req and ld_addr equals the word address of any valid entry.
  - If ld_req && !hit: dm_A=ld_addr, dm_WE=0, ld_stall=0. The load owns the bus; no drain this cycle.
  - Otherwise, if the buffer is non-empty: dm_A=head addr, dm_WE=1. The head dequeues on posedge. ld_stall=hit.
  - If empty and no load: dm_WE=0, dm_A=0.
- Memory format conversion on drain (the memory takes byte stores from WD[7:0] and half stores from WD[15:0])
  - Single-byte BE: dm_WD[7:0] = selected lane byte.
  - BE 1100: dm_WD[15:0] = lane[31:16].
  - BE 0011 / 1111: lane data unchanged.
  - Unused dm_WD bits = 0.
  - dm_BE = entry BE. Only the legal codes 0001, 0010, 0100, 1000, 0011, 1100, 1111 are ever emitted.
- Latency
  - A store accepted at edge N is written to memory at edge N+1 at the earliest (empty buffer, no load).
  - A stalled load is released the cycle after the last matching entry dequeues.
- Simultaneous enqueue and dequeue: count unchanged; pointers wrap modulo DEPTH.
- Forward progress: a hitting load never blocks draining, so a stall lasts at most count cycles.

Optional Feature:
- Macro STBUF_MERGE_EN.
- Defined:
  - An accepted store whose word address equals the tail-most valid entry, and that entry is not dequeuing this cycle, merges into that entry instead of allocating a new one.
  - Merge: BE_new = BE_old | BE_st; lanes covered by the new store are overwritten.
  - Merge happens only if BE_new is a legal code (0011, 1100, 1111). Otherwise the store allocates a new entry.
  - When a merge happens, count is unchanged and st_ready ignores full.
- Undefined: every accepted store allocates its own entry.

Test Plan:
- Reset, then sw 0x12345678 @0x010 with buffer idle -> next cycle dm_WE=1, dm_A=0x004, dm_BE=1111, dm_WD=0x12345678; then empty=1.
- sb 0xAB @0x013 -> dm_BE=1000, dm_WD=0x000000AB. sh 0xBEEF @0x022 -> dm_BE=1100, dm_WD=0x0000BEEF.
- Misaligned stores:
  - sh @0x001 -> align_err pulses 1 cycle, count stays 0, dm_WE never 1.
  - sw @0x002 -> same response.
- Fill DEPTH=4 with ld_req held to a non-matching address -> count=4, st_ready=0, dm_WE=0. A 5th store is held; releasing ld_req drains 4 entries in order.
- Load hit:
  - Stores to 0x040 then 0x044, then ld_addr=0x011 (word of 0x044) -> ld_stall=1 for 2 cycles while both drain.
  - ld_stall=0 in the 3rd cycle with dm_A=0x011.
- Merge:
  - With STBUF_MERGE_EN: sb @0x020 and sb @0x021 on consecutive cycles while a load blocks draining -> count=1, entry BE=0011.
  - Without STBUF_MERGE_EN -> count=2.
  - Reset mid-sequence -> count=0, dm_WE=0.
